uncache_bus_arbiter: RTL and testbench
======================================

// Module: uncache_bus_arbiter
// PURPOSE
//  Shares the single uncached system bus (UART/uncache space) between pipeline-stage controllers.
//  Requesters: IF controller (index 0), MEM controller (index 1), further masters by parameter.
//  Grants one-hot ownership with round-robin fairness. Holds the grant while the owner keeps its request high.
//  Watchdog: if the slave stays silent too long, the arbiter revokes the grant and flags a bus error to the owner.
// PARAMETERS
//  NUM_MASTERS     2    number of requesters, 2..8
//  OWNER_W         1    owner-index width, = clog2(NUM_MASTERS)
//  TIMEOUT_CYCLES  255  granted cycles without slave_rdy before timeout, 2..2^CNT_W-1
//  CNT_W           8    watchdog counter width
// PORTS
//  clk          in   1            system clock, rising edge
//  resetn       in   1            asynchronous, active-low reset
//  req          in   NUM_MASTERS  per-master bus request, level; held for the whole transfer
//  slave_rdy    in   1            slave data-ready/ack pulse; one per completed beat
//  grant        out  NUM_MASTERS  one-hot grant, registered
//  owner        out  OWNER_W      index of the granted master; 0 when idle
//  bus_busy     out  1            high in GRANT and RELEASE
//  timeout_err  out  NUM_MASTERS  one-cycle pulse to the master whose grant was revoked by the watchdog
// BEHAVIOUR
//  Reset values: grant=0, owner=0, bus_busy=0, timeout_err=0, state=IDLE, rr_ptr=0, wd_cnt=0, lockout=0.
//  Reset mid-transfer drops grant immediately and does not wait for a clock edge.
//  FSM states:
//   IDLE:
//    - Eligible masters = req & ~lockout.
//    - If any master is eligible, pick the first one scanning from rr_ptr upward, with modulo NUM_MASTERS wrap.
//    - On the same edge: set grant/owner, set rr_ptr = winner+1 (mod N), clear wd_cnt, go to GRANT.
//    - Latency: req high before edge k -> grant visible after edge k (1 cycle).
//   GRANT:
//    - req[owner] low: drop grant -> RELEASE, with no error.
//    - Otherwise, slave_rdy high: clear wd_cnt and stay in GRANT.
//    - Otherwise, wd_cnt == TIMEOUT_CYCLES-1: drop grant, pulse timeout_err[owner], set lockout[owner] -> RELEASE.
//    - Otherwise, wd_cnt increments.
//   RELEASE:
//    - Single turnaround cycle: grant=0, bus_busy=1 -> IDLE.
//    - Minimum gap between two grants is therefore 2 cycles.
//  Lockout: lockout[i] clears on the first cycle req[i] is sampled low; a timed-out master must drop req to re-arbitrate.
//  Simultaneous events, priority order: req[owner] drop > slave_rdy > timeout.
//   - Release in the timeout cycle gives no error.
//   - slave_rdy in the threshold cycle clears the counter, with no error.
//  A request that appears while another master owns the bus waits; it is not preempted and gains no priority.
//  Requests from non-owners are ignored in GRANT/RELEASE and arbitrated on the next IDLE cycle.
//  Requests are never queued or latched.
//  wd_cnt saturates conceptually at TIMEOUT_CYCLES-1 and never wraps, because the timeout fires first.
//  grant is always one-hot or zero, and owner is stable for the whole GRANT state.
// TESTING
//  1 Single requester: req=01 held 5 cycles, with slave_rdy every 2 cycles.
//    -> grant=01 one cycle after req; grant=00 one cycle after req drops; bus_busy high through RELEASE.
//  2 Contention after reset: req=11 asserted together.
//    -> master 0 granted first.
//    -> After it drops req, master 1 is granted exactly 2 cycles after grant falls (RELEASE + IDLE).
//  3 Round-robin fairness: both masters request continuously, each releasing after 3 cycles.
//    -> grants alternate 0,1,0,1 over 8 transfers; no master is granted twice in a row.
//  4 Timeout: TIMEOUT_CYCLES=4, req=10, slave_rdy never asserts.
//    -> timeout_err=10 for exactly 1 cycle, 4 cycles after the grant; grant drops.
//    -> Master 1 is not regranted while req stays high; it is regranted after req goes low for 1 cycle and back high.
//  5 Boundary collisions:
//    -> slave_rdy in the threshold cycle: no error, grant held.
//    -> req drop in the threshold cycle: no error, normal release.
//  6 Async reset: resetn pulled low mid-GRANT between clock edges.
//    -> grant=0 and bus_busy=0 immediately.
//    -> After release, req=11 grants master 0 (rr_ptr reset).

Source files
------------

// File: rtl/uncache_bus_arbiter.sv
// Round-robin arbiter for the shared uncached system bus, with a slave-silence watchdog
// that revokes the grant, flags the owner and locks it out until it drops its request.
module uncache_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int OWNER_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   slave_rdy,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [OWNER_W-1:0]     owner,
  output logic                   bus_busy,
  output logic [NUM_MASTERS-1:0] timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] lockout_q, lockout_d;
  logic [NUM_MASTERS-1:0] terr_q, terr_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       wd_cnt_q, wd_cnt_d;

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] lock_set;
  logic [OWNER_W-1:0]     cand;
  logic [OWNER_W-1:0]     winner;
  logic                   found;

  // Scan eligible masters starting at rr_ptr, wrapping at NUM_MASTERS (not at 2^OWNER_W).
  always_comb begin
    // NOTE: every signal driven here gets a default first; a branch that skips one would infer a latch.
    eligible = req & ~lockout_q;
    found    = 1'b0;
    winner   = '0;
    cand     = rr_ptr_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = (cand == OWNER_W'(NUM_MASTERS - 1)) ? '0 : cand + OWNER_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    wd_cnt_d = wd_cnt_q;
    terr_d   = '0;
    lock_set = '0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_GRANT;
          grant_d  = NUM_MASTERS'(1) << winner;
          owner_d  = winner;
          rr_ptr_d = (winner == OWNER_W'(NUM_MASTERS - 1)) ? '0 : winner + OWNER_W'(1);
          wd_cnt_d = '0;
        end
      end
      S_GRANT: begin
        // Priority: owner release, then slave response, then watchdog expiry.
        if (!req[owner_q]) begin
          state_d = S_RELEASE;
          grant_d = '0;
          owner_d = '0;
        end else if (slave_rdy) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = S_RELEASE;
          grant_d  = '0;
          owner_d  = '0;
          terr_d   = grant_q;
          lock_set = grant_q;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // A locked-out master regains eligibility only after it has been seen with req low.
    lockout_d = (lockout_q & req) | lock_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      wd_cnt_q  <= '0;
      lockout_q <= '0;
      terr_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_cnt_q  <= wd_cnt_d;
      lockout_q <= lockout_d;
      terr_q    <= terr_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign bus_busy    = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uncache_bus_arbiter.sv
// Scoreboard bench for uncache_bus_arbiter: the driver steps an ownership-level model per edge
// and queues expected outputs; a negedge monitor pops and compares against the DUT.
module tb_uncache_bus_arbiter;

  localparam int N  = 2;
  localparam int OW = 1;
  localparam int TO = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req;
  logic          slave_rdy;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          bus_busy;
  logic [N-1:0]  timeout_err;

  uncache_bus_arbiter #(
    .NUM_MASTERS   (N),
    .OWNER_W       (OW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .slave_rdy  (slave_rdy),
    .grant      (grant),
    .owner      (owner),
    .bus_busy   (bus_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    int           owner;
    logic         busy;
    logic [N-1:0] terr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: who owns the bus, whether a turnaround cycle is pending,
  // how long the slave has been silent, who is next in line, who is locked out.
  int           m_owner  = -1;
  bit           m_turn   = 1'b0;
  int           m_silent = 0;
  int           m_next   = 0;
  logic [N-1:0] m_locked = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_turn   = 1'b0;
    m_silent = 0;
    m_next   = 0;
    m_locked = '0;
  endtask

  // Advance the model across one rising edge and queue the outputs it should show afterwards.
  task automatic model_step(input logic [N-1:0] r, input logic s);
    exp_t         e;
    logic [N-1:0] terr;
    int           c;
    terr = '0;
    if (!resetn) begin
      model_reset();
    end else begin
      if (m_owner >= 0) begin
        if (!bit_of(r, m_owner)) begin
          m_owner = -1;
          m_turn  = 1'b1;
        end else if (s) begin
          m_silent = 0;
        end else if (m_silent == TO - 1) begin
          terr     = N'(1) << m_owner;
          m_locked = m_locked | terr;
          m_owner  = -1;
          m_turn   = 1'b1;
        end else begin
          m_silent++;
        end
      end else if (m_turn) begin
        m_turn = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_next + k) % N;
          if (bit_of(r, c) && !bit_of(m_locked, c)) begin
            m_owner  = c;
            m_next   = (c + 1) % N;
            m_silent = 0;
            break;
          end
        end
      end
      m_locked = m_locked & r;
    end
    e.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.owner = (m_owner >= 0) ? m_owner : 0;
    e.busy  = (m_owner >= 0) || m_turn;
    e.terr  = terr;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic s);
    req       = r;
    slave_rdy = s;
    @(posedge clk);
    model_step(r, s);
    #2;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_busy", 32'(bus_busy), 32'd0);
    check("async_rst_owner", 32'(owner), 32'd0);
    check("async_rst_terr", 32'(timeout_err), 32'd0);
    cyc(req, 1'b0);
    cyc(req, 1'b0);
    resetn = 1'b1;
  endtask

  // Monitor: outputs are presented every cycle, so compare whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("owner", 32'(owner), 32'(e.owner));
        check("bus_busy", 32'(bus_busy), 32'(e.busy));
        check("timeout_err", 32'(timeout_err), 32'(e.terr));
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    int           held;
    resetn    = 1'b1;
    req       = '0;
    slave_rdy = 1'b0;
    #3;
    pulse_reset();

    // Single requester with periodic slave responses.
    for (int i = 0; i < 5; i++) cyc(2'b01, 1'(i % 2));
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);

    // Contention straight after reset: master 0 first, master 1 two cycles after release.
    pulse_reset();
    for (int i = 0; i < 3; i++) cyc(2'b11, 1'b0);
    for (int i = 0; i < 4; i++) cyc(2'b10, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);

    // Continuous contention, each owner releasing after three granted cycles.
    held = 0;
    for (int i = 0; i < 48; i++) begin
      r = 2'b11;
      if (m_owner >= 0) begin
        held++;
        if (held >= 3) begin
          r    = r & ~(N'(1) << m_owner);
          held = 0;
        end
      end
      cyc(r, 1'b1);
    end
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);

    // Watchdog expiry, lockout while req stays high, re-arbitration after a low cycle.
    for (int i = 0; i < 9; i++) cyc(2'b10, 1'b0);
    cyc(2'b00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b10, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);

    // slave_rdy coinciding with the threshold cycle.
    cyc(2'b01, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b01, 1'b0);
    cyc(2'b01, 1'b1);
    for (int i = 0; i < 2; i++) cyc(2'b01, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);

    // Owner release coinciding with the threshold cycle.
    cyc(2'b01, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b01, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);

    // Asynchronous reset in the middle of a grant, then arbitration from a cleared pointer.
    for (int i = 0; i < 2; i++) cyc(2'b10, 1'b0);
    cyc(2'b11, 1'b0);
    pulse_reset();
    for (int i = 0; i < 3; i++) cyc(2'b11, 1'b0);
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);

    // Randomised requests and slave responses.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(0, 5) == 0) r = r ^ (N'(1) << m);
      end
      cyc(r, 1'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 4; i++) cyc(2'b00, 1'b0);

    @(negedge clk);
    #1;
    check("enough_checks", 32'(checks > 1000), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
